// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Bus-side line-fill / write-back engine for a direct-mapped
//               cache. Optionally writes back the dirty victim, then refills
//               the missing line word by word into the cache data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int ENTRY_NUM    = 16,
    parameter int ENTRYSEL_WID = (ENTRY_NUM == 1) ? 1 : $clog2(ENTRY_NUM),
    parameter int TAG_WID      = 14,
    parameter int LINE_WORDS   = 4,
    parameter int OFFSET_WID   = $clog2(LINE_WORDS),
    parameter int DATA_WID     = 32,
    parameter int AW           = TAG_WID + ENTRYSEL_WID + OFFSET_WID
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           line_miss,
    input  logic                           replace_dirty,
    input  logic [ENTRYSEL_WID-1:0]        entry_replace_sel,
    input  logic [TAG_WID-1:0]             miss_tag,
    input  logic [TAG_WID-1:0]             victim_tag,
    output logic                           line_refill,
    output logic [TAG_WID-1:0]             refill_tag,
    output logic                           writeback_ok,
    output logic                           busy,
    output logic [ENTRYSEL_WID+OFFSET_WID-1:0] cmem_addr,
    output logic                           cmem_we,
    output logic [DATA_WID-1:0]            cmem_wdata,
    input  logic [DATA_WID-1:0]            cmem_rdata,
    output logic                           bus_req,
    output logic                           bus_we,
    output logic [AW-1:0]                  bus_addr,
    output logic [DATA_WID-1:0]            bus_wdata,
    input  logic [DATA_WID-1:0]            bus_rdata,
    input  logic                           bus_ack
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WB_RD   = 3'd1;
    localparam logic [2:0] c_WB_LD   = 3'd2;
    localparam logic [2:0] c_WB_BUS  = 3'd3;
    localparam logic [2:0] c_WB_DONE = 3'd4;
    localparam logic [2:0] c_RF_BUS  = 3'd5;
    localparam logic [2:0] c_RF_DONE = 3'd6;

    localparam logic [OFFSET_WID-1:0] c_LAST_CNT = OFFSET_WID'(LINE_WORDS - 1);
    localparam logic [OFFSET_WID-1:0] c_CNT_ONE  = OFFSET_WID'(1);

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [OFFSET_WID-1:0]   r_cnt;
    logic [OFFSET_WID-1:0]   w_cnt_nxt;
    logic [ENTRYSEL_WID-1:0] r_ent;
    logic [TAG_WID-1:0]      r_mtag;
    logic [TAG_WID-1:0]      r_vtag;
    logic [DATA_WID-1:0]     r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_ent   <= '0;
            r_mtag  <= '0;
            r_vtag  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Request context is captured only on acceptance; later input changes are ignored.
            if (r_state == c_IDLE && line_miss) begin
                r_ent  <= entry_replace_sel;
                r_mtag <= miss_tag;
                r_vtag <= victim_tag;
            end
            if (r_state == c_WB_LD) begin
                r_wdata <= cmem_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        line_refill  = 1'b0;
        refill_tag   = '0;
        writeback_ok = 1'b0;
        busy         = (r_state != c_IDLE);
        cmem_addr    = '0;
        cmem_we      = 1'b0;
        cmem_wdata   = '0;
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;

        case (r_state)
            c_IDLE: begin
                if (line_miss) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = replace_dirty ? c_WB_RD : c_RF_BUS;
                end
            end
            c_WB_RD: begin
                cmem_addr   = {r_ent, r_cnt};
                w_state_nxt = c_WB_LD;
            end
            c_WB_LD: begin
                w_state_nxt = c_WB_BUS;
            end
            c_WB_BUS: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = {r_vtag, r_ent, r_cnt};
                bus_wdata = r_wdata;
                if (bus_ack) begin
                    if (r_cnt == c_LAST_CNT) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_WB_DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                        w_state_nxt = c_WB_RD;
                    end
                end
            end
            c_WB_DONE: begin
                writeback_ok = 1'b1;
                w_state_nxt  = c_RF_BUS;
            end
            c_RF_BUS: begin
                bus_req  = 1'b1;
                bus_addr = {r_mtag, r_ent, r_cnt};
                // Read data flows straight into the RAM in the ack cycle.
                if (bus_ack) begin
                    cmem_we    = 1'b1;
                    cmem_addr  = {r_ent, r_cnt};
                    cmem_wdata = bus_rdata;
                    w_cnt_nxt  = r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST_CNT) begin
                        w_state_nxt = c_RF_DONE;
                    end
                end
            end
            c_RF_DONE: begin
                line_refill = 1'b1;
                refill_tag  = r_mtag;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_refill_ctrl
// Description : Directed bench for cache_refill_ctrl: per-cycle vector table
//               plus hand-written wait-state and mid-refill reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

    typedef struct packed {
        logic        busy;
        logic        bus_req;
        logic        bus_we;
        logic [19:0] bus_addr;
        logic [31:0] bus_wdata;
        logic        cmem_we;
        logic [5:0]  cmem_addr;
        logic [31:0] cmem_wdata;
        logic        line_refill;
        logic [13:0] refill_tag;
        logic        writeback_ok;
    } out_t;

    typedef struct {
        logic        miss;
        logic        dirty;
        logic [3:0]  ent;
        logic [13:0] mtag;
        logic [13:0] vtag;
        logic        ack;
        logic [31:0] brd;
        logic [31:0] crd;
        logic        cchk;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_miss;
    logic        replace_dirty;
    logic [3:0]  entry_replace_sel;
    logic [13:0] miss_tag;
    logic [13:0] victim_tag;
    logic        line_refill;
    logic [13:0] refill_tag;
    logic        writeback_ok;
    logic        busy;
    logic [5:0]  cmem_addr;
    logic        cmem_we;
    logic [31:0] cmem_wdata;
    logic [31:0] cmem_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [19:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .line_miss         (line_miss),
        .replace_dirty     (replace_dirty),
        .entry_replace_sel (entry_replace_sel),
        .miss_tag          (miss_tag),
        .victim_tag        (victim_tag),
        .line_refill       (line_refill),
        .refill_tag        (refill_tag),
        .writeback_ok      (writeback_ok),
        .busy              (busy),
        .cmem_addr         (cmem_addr),
        .cmem_we           (cmem_we),
        .cmem_wdata        (cmem_wdata),
        .cmem_rdata        (cmem_rdata),
        .bus_req           (bus_req),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_rdata         (bus_rdata),
        .bus_ack           (bus_ack)
    );

    function automatic out_t pack_out();
        out_t o;
        o.busy = busy;  o.bus_req = bus_req;  o.bus_we = bus_we;
        o.bus_addr = bus_addr;  o.bus_wdata = bus_wdata;
        o.cmem_we = cmem_we;  o.cmem_addr = cmem_addr;  o.cmem_wdata = cmem_wdata;
        o.line_refill = line_refill;  o.refill_tag = refill_tag;
        o.writeback_ok = writeback_ok;
        return o;
    endfunction

    // Fields without meaning in the expected cycle are treated as don't-care.
    function automatic out_t masked(out_t o, out_t e, logic cchk);
        out_t r = o;
        if (!e.bus_req) begin
            r.bus_we = 1'b0;  r.bus_addr = '0;  r.bus_wdata = '0;
        end
        if (!e.bus_we) r.bus_wdata = '0;
        if (!(e.cmem_we || cchk)) r.cmem_addr = '0;
        if (!e.cmem_we) r.cmem_wdata = '0;
        if (!e.line_refill) r.refill_tag = '0;
        return r;
    endfunction

    function automatic out_t e_busy();
        out_t e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic out_t e_rd(logic [13:0] tag, logic [3:0] ent, logic [1:0] off,
                                  logic ack, logic [31:0] d);
        out_t e = e_busy();
        e.bus_req = 1'b1;
        e.bus_addr = {tag, ent, off};
        if (ack) begin
            e.cmem_we = 1'b1;  e.cmem_addr = {ent, off};  e.cmem_wdata = d;
        end
        return e;
    endfunction

    function automatic out_t e_wr(logic [13:0] tag, logic [3:0] ent, logic [1:0] off,
                                  logic [31:0] d);
        out_t e = e_busy();
        e.bus_req = 1'b1;  e.bus_we = 1'b1;
        e.bus_addr = {tag, ent, off};  e.bus_wdata = d;
        return e;
    endfunction

    function automatic out_t e_caddr(logic [3:0] ent, logic [1:0] off);
        out_t e = e_busy();
        e.cmem_addr = {ent, off};
        return e;
    endfunction

    function automatic out_t e_done(logic [13:0] tag);
        out_t e = e_busy();
        e.line_refill = 1'b1;  e.refill_tag = tag;
        return e;
    endfunction

    function automatic out_t e_wb();
        out_t e = e_busy();
        e.writeback_ok = 1'b1;
        return e;
    endfunction

    task automatic chk(string nm, out_t act, out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add(logic miss, logic dirty, logic [3:0] ent, logic [13:0] mt,
                       logic [13:0] vt, logic ack, logic [31:0] brd, logic [31:0] crd,
                       logic cchk, out_t e);
        vec_t v;
        v.miss = miss;  v.dirty = dirty;  v.ent = ent;  v.mtag = mt;  v.vtag = vt;
        v.ack = ack;  v.brd = brd;  v.crd = crd;  v.cchk = cchk;  v.exp = e;
        tbl.push_back(v);
    endtask

    // Clean miss with a fixed number of wait cycles before every bus_ack.
    task automatic run_clean(string nm, logic [3:0] ent, logic [13:0] tag,
                             logic [31:0] base, int waits);
        @(posedge clk); #1;
        line_miss = 1'b1;  replace_dirty = 1'b0;  entry_replace_sel = ent;
        miss_tag = tag;  victim_tag = 14'h3FFF;  bus_ack = 1'b0;
        @(posedge clk); #1;
        line_miss = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j <= waits; j++) begin
                bus_ack   = (j == waits);
                bus_rdata = (j == waits) ? base + 32'(w) : 32'hDEAD_BEEF;
                @(negedge clk);
                chk($sformatf("%s_w%0d_c%0d", nm, w, j),
                    masked(pack_out(), e_rd(tag, ent, 2'(w), bus_ack, base + 32'(w)), 1'b0),
                    e_rd(tag, ent, 2'(w), bus_ack, base + 32'(w)));
                @(posedge clk); #1;
            end
        end
        bus_ack = 1'b0;
        @(negedge clk);
        chk({nm, "_done"}, masked(pack_out(), e_done(tag), 1'b0), e_done(tag));
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_idle"}, pack_out(), '0);
    endtask

    initial begin
        rst = 1'b1;  line_miss = 1'b1;  replace_dirty = 1'b0;
        entry_replace_sel = '0;  miss_tag = '0;  victim_tag = '0;
        cmem_rdata = '0;  bus_rdata = '0;  bus_ack = 1'b0;

        // Clean miss; line_miss/ent/tag wiggle during refill and must be ignored.
        add(0, 0, 4'h0, 14'h000, 14'h000, 1, 32'hDEAD, 0, 0, '0);
        add(1, 0, 4'h3, 14'h0A5, 14'h111, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++)
            add(i[0], 1, 4'hC, 14'h3333, 14'h2222, 1, 32'h100 + 32'(i), 0, 0,
                e_rd(14'h0A5, 4'h3, 2'(i), 1'b1, 32'h100 + 32'(i)));
        add(1, 1, 4'hC, 14'h3333, 14'h2222, 0, 0, 0, 0, e_done(14'h0A5));
        add(0, 0, 4'h0, 14'h000, 14'h000, 0, 0, 0, 0, '0);
        // Dirty miss: write back A0..A3 to victim tag, then refill.
        add(1, 1, 4'h7, 14'h2C3, 14'h011, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            add(0, 0, 0, 0, 0, 0, 0, 32'hBAD0, 1, e_caddr(4'h7, 2'(i)));
            add(0, 0, 0, 0, 0, 0, 0, 32'hA0 + 32'(i), 0, e_busy());
            add(0, 0, 0, 0, 0, 1, 32'hFFFF, 32'hBAD1, 0,
                e_wr(14'h011, 4'h7, 2'(i), 32'hA0 + 32'(i)));
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, e_wb());
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 1, 32'h200 + 32'(i), 0, 0,
                e_rd(14'h2C3, 4'h7, 2'(i), 1'b1, 32'h200 + 32'(i)));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, e_done(14'h2C3));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        @(posedge clk); #1;
        bus_ack = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_state", pack_out(), '0);
        @(posedge clk); #1;
        rst = 1'b0;  line_miss = 1'b0;  bus_ack = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            line_miss = tbl[i].miss;  replace_dirty = tbl[i].dirty;
            entry_replace_sel = tbl[i].ent;  miss_tag = tbl[i].mtag;
            victim_tag = tbl[i].vtag;  bus_ack = tbl[i].ack;
            bus_rdata = tbl[i].brd;  cmem_rdata = tbl[i].crd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), masked(pack_out(), tbl[i].exp, tbl[i].cchk),
                tbl[i].exp);
        end
        line_miss = 1'b0;  bus_ack = 1'b0;

        run_clean("wait3", 4'h5, 14'h1FF, 32'h400, 3);

        // Reset during the second refill word.
        @(posedge clk); #1;
        line_miss = 1'b1;  replace_dirty = 1'b0;  entry_replace_sel = 4'h2;
        miss_tag = 14'h055;
        @(posedge clk); #1;
        line_miss = 1'b0;  bus_ack = 1'b1;  bus_rdata = 32'h300;
        @(negedge clk);
        chk("rst_w0", masked(pack_out(), e_rd(14'h055, 4'h2, 2'd0, 1'b1, 32'h300), 1'b0),
            e_rd(14'h055, 4'h2, 2'd0, 1'b1, 32'h300));
        @(posedge clk); #1;
        bus_ack = 1'b0;  rst = 1'b1;
        @(negedge clk);
        chk("rst_w1", masked(pack_out(), e_rd(14'h055, 4'h2, 2'd1, 1'b0, 0), 1'b0),
            e_rd(14'h055, 4'h2, 2'd1, 1'b0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d", k), pack_out(), '0);
            @(posedge clk); #1;
        end
        run_clean("post_rst", 4'h9, 14'h2AA, 32'h500, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
